// File: rtl/riscv_trace_pkg.sv
// Shared trace types: event kinds, the default-width trace entry and a packing helper.
package riscv_trace_pkg;

  localparam int KIND_W    = 2;
  localparam int REG_W     = 5;
  localparam int TR_DATA_W = 32;
  localparam int TR_ADDR_W = 9;
  localparam int TR_TS_W   = 16;

  typedef enum logic [KIND_W-1:0] {
    REG   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [REG_W-1:0]       rnum;
    logic [TR_ADDR_W-1:0]   addr;
    logic [TR_DATA_W-1:0]   data;
    logic [TR_TS_W-1:0]     ts;
  } trace_entry_t;

  function automatic trace_entry_t mk_entry(input trace_kind_e k, input logic [REG_W-1:0] r,
                                            input logic [TR_ADDR_W-1:0] a,
                                            input logic [TR_DATA_W-1:0] d,
                                            input logic [TR_TS_W-1:0] t);
    trace_entry_t e;
    e.kind = k;
    e.rnum = r;
    e.addr = a;
    e.data = d;
    e.ts   = t;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic DEPTH-entry register FIFO with flush; head is read straight from registered storage.
// Caller only asserts i_push when space exists (or a pop frees the slot) and i_pop when non-empty.
module trace_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  entry_t                 i_dat,
  input  logic                   i_pop,
  output entry_t                 o_head,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      // On full-and-pop the write lands in the slot the head is vacating.
      if (i_push) begin
        r_mem[r_wptr] <= i_dat;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      if (i_push && !i_pop)      r_level <= r_level + 1'b1;
      else if (!i_push && i_pop) r_level <= r_level - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_full  = (r_level == FULL_LVL);

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: classifies core events, timestamps them and queues them; never stalls the core.
// Build option RISCV_TRACE_MEM_EN adds LOAD/STORE capture; without it only register writes are logged.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_write_sig,
  input  logic [REG_W-1:0]       reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   flush,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [KIND_W-1:0]      tr_kind,
  output logic [REG_W-1:0]       tr_reg,
  output logic [ADDR_W-1:0]      tr_addr,
  output logic [DATA_W-1:0]      tr_data,
  output logic [TS_W-1:0]        tr_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt,
  output logic                   overflow
);

`ifdef RISCV_TRACE_MEM_EN
  typedef struct packed {
    trace_kind_e         kind;
    logic [REG_W-1:0]    rnum;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [TS_W-1:0]     ts;
  } entry_t;
`else
  typedef struct packed {
    trace_kind_e         kind;
    logic [REG_W-1:0]    rnum;
    logic [DATA_W-1:0]   data;
    logic [TS_W-1:0]     ts;
  } entry_t;
`endif

  logic [TS_W-1:0] r_ts;
  logic [15:0]     r_drop_cnt;
  logic            r_overflow;
  logic            w_evt;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  entry_t          w_entry;
  entry_t          w_head;

  // Store beats load beats plain register write; x0 writes are not architecturally visible.
  always_comb begin
    w_evt   = 1'b0;
    w_entry = '0;
    w_entry.ts = r_ts;
`ifdef RISCV_TRACE_MEM_EN
    if (wr) begin
      w_evt        = 1'b1;
      w_entry.kind = STORE;
      w_entry.addr = addr;
      w_entry.data = wr_data;
    end else if (rd) begin
      w_evt        = 1'b1;
      w_entry.kind = LOAD;
      w_entry.rnum = reg_write_sig ? reg_num : '0;
      w_entry.addr = addr;
      w_entry.data = rd_data;
    end else
`endif
    if (reg_write_sig && (reg_num != '0)) begin
      w_evt        = 1'b1;
      w_entry.kind = REG;
      w_entry.rnum = reg_num;
      w_entry.data = reg_data;
    end
  end

  assign tr_valid = (level != '0);
  assign w_pop    = tr_valid && tr_ready;
  assign w_push   = w_evt && (!w_full || w_pop);

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_dat   (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (level),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ts       <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (flush) begin
        r_drop_cnt <= '0;
        r_overflow <= 1'b0;
      end else if (w_evt && !w_push) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign tr_kind  = w_head.kind;
  assign tr_reg   = w_head.rnum;
  assign tr_data  = w_head.data;
  assign tr_ts    = w_head.ts;
  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;

`ifdef RISCV_TRACE_MEM_EN
  assign tr_addr = w_head.addr;
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{wr, rd, addr, wr_data, rd_data};
  assign tr_addr      = '0;
`endif

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench for riscv_trace_buffer: stimulus queues expected entries, a negedge monitor checks pops.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic        rd;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        flush;
  logic        tr_valid;
  logic        tr_ready;
  logic [1:0]  tr_kind;
  logic [4:0]  tr_reg;
  logic [8:0]  tr_addr;
  logic [31:0] tr_data;
  logic [15:0] tr_ts;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic        overflow;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(16), .TS_W(16)) dut (
    .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .flush(flush), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_kind(tr_kind), .tr_reg(tr_reg), .tr_addr(tr_addr), .tr_data(tr_data),
    .tr_ts(tr_ts), .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  int           n_chk  = 0;
  int           n_fail = 0;
  trace_entry_t exp_q[$];
  trace_entry_t mon_act;
  trace_entry_t mon_exp;
  logic [15:0]  tb_ts;

  // Reference cycle counter: free-running from reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  always @(negedge clk) begin
    if (reset && tr_valid && tr_ready) begin
      mon_act = mk_entry(trace_kind_e'(tr_kind), tr_reg, tr_addr, tr_data, tr_ts);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_entry: got %h, expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL entry: got %h, expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
    flush = 1'b0;
  endtask

  task automatic drive_reg(input logic [4:0] r, input logic [31:0] d);
    reg_write_sig = 1'b1; reg_num = r; reg_data = d;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tr_valid) && n < 100) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [15:0] t0;
    int          exp_lvl;
    idle_inputs();
    tr_ready = 1'b0;
    reset    = 1'b0;
    step();
    step();
    check("reset_valid", 64'(tr_valid), 64'(0));
    check("reset_level", 64'(level), 64'(0));
    check("reset_stats", 64'({drop_cnt, overflow}), 64'(0));
    check("reset_fields", 64'({tr_kind, tr_reg, tr_addr, tr_data, tr_ts}), 64'(0));

    // First event at timestamp 3, one-cycle latency.
    reset = 1'b1;
    step(); step(); step();
    drive_reg(5'd5, 32'hDEADBEEF);
    exp_q.push_back(mk_entry(REG, 5'd5, 9'h0, 32'hDEADBEEF, 16'd3));
    step();
    idle_inputs();
    check("first_valid", 64'(tr_valid), 64'(1));
    check("first_level", 64'(level), 64'(1));
    tr_ready = 1'b1;
    step();
    check("first_drained", 64'(level), 64'(0));

    // x0 write alone is not an event.
    drive_reg(5'd0, 32'h11111111);
    step();
    idle_inputs();
    check("x0_level", 64'(level), 64'(0));
    check("x0_valid", 64'(tr_valid), 64'(0));

    // Store and load together: store wins.
    wr = 1'b1; rd = 1'b1; addr = 9'h040; wr_data = 32'h12; rd_data = 32'h55;
`ifdef RISCV_TRACE_MEM_EN
    exp_q.push_back(mk_entry(STORE, 5'd0, 9'h040, 32'h12, tb_ts));
    exp_lvl = 1;
`else
    exp_lvl = 0;
`endif
    step();
    idle_inputs();
    check("store_level", 64'(level), 64'(exp_lvl));
    step();

    // Load carrying a register write.
    rd = 1'b1; addr = 9'h1FF; rd_data = 32'hAB; drive_reg(5'd7, 32'hCC);
`ifdef RISCV_TRACE_MEM_EN
    exp_q.push_back(mk_entry(LOAD, 5'd7, 9'h1FF, 32'hAB, tb_ts));
`else
    exp_q.push_back(mk_entry(REG, 5'd7, 9'h0, 32'hCC, tb_ts));
`endif
    step();
    idle_inputs();
    check("load_level", 64'(level), 64'(1));
    wait_drain("load_drain");

    // Overfill with consumer stalled: 16 kept, 4 dropped.
    tr_ready = 1'b0;
    t0 = tb_ts;
    for (int i = 0; i < 20; i++) begin
      drive_reg(5'(i + 1), 32'h100 + 32'(i));
      if (i < 16) exp_q.push_back(mk_entry(REG, 5'(i + 1), 9'h0, 32'h100 + 32'(i), t0 + 16'(i)));
      step();
    end
    idle_inputs();
    check("full_level", 64'(level), 64'(16));
    check("full_drops", 64'(drop_cnt), 64'(4));
    check("full_overflow", 64'(overflow), 64'(1));

    // Full with simultaneous pop and push: no drop, new entry at tail.
    tr_ready = 1'b1;
    drive_reg(5'd9, 32'h99);
    exp_q.push_back(mk_entry(REG, 5'd9, 9'h0, 32'h99, tb_ts));
    step();
    idle_inputs();
    check("fullpop_level", 64'(level), 64'(16));
    check("fullpop_drops", 64'(drop_cnt), 64'(4));
    wait_drain("fullpop_drain");

    // Flush with a same-cycle event clears everything.
    tr_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive_reg(5'd3, 32'(i));
      step();
    end
    check("preflush_drops", 64'(drop_cnt), 64'(6));
    drive_reg(5'd3, 32'hF00D);
    flush = 1'b1;
    step();
    idle_inputs();
    check("flush_level", 64'(level), 64'(0));
    check("flush_stats", 64'({drop_cnt, overflow}), 64'(0));
    check("flush_valid", 64'(tr_valid), 64'(0));
    step();
    check("flush_discard", 64'(level), 64'(0));

    // Reset asserted mid-drain.
    for (int i = 0; i < 3; i++) begin
      drive_reg(5'd10 + 5'(i), 32'hA0 + 32'(i));
      exp_q.push_back(mk_entry(REG, 5'd10 + 5'(i), 9'h0, 32'hA0 + 32'(i), tb_ts));
      step();
    end
    idle_inputs();
    tr_ready = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 64'(tr_valid), 64'(0));
    check("midrst_level", 64'(level), 64'(0));
    check("midrst_ts", 64'(tr_ts), 64'(0));
    step();
    reset = 1'b1;
    drive_reg(5'd4, 32'h44);
    exp_q.push_back(mk_entry(REG, 5'd4, 9'h0, 32'h44, 16'd0));
    step();
    idle_inputs();
    check("postrst_valid", 64'(tr_valid), 64'(1));
    wait_drain("postrst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
